// File: rtl/mux_reg_n_if.sv
// Channel bus for mux_reg_n: flattened inputs, select/mode/enable controls and the held result.
interface mux_reg_n_if #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned NUM_IN = 2,
    parameter int unsigned SEL_W  = 1
);
    logic [NUM_IN*WIDTH-1:0] d;
    logic [SEL_W-1:0]        sel;
    logic [1:0]              mode;
    logic                    enb_n;
    logic [WIDTH-1:0]        q;
    logic                    q_valid;
    logic [SEL_W-1:0]        chan;
    logic                    scan_done;

    // Source of channel data and controls.
    modport master (
        output d, sel, mode, enb_n,
        input  q, q_valid, chan, scan_done
    );

    // The multiplexer-register itself.
    modport slave (
        input  d, sel, mode, enb_n,
        output q, q_valid, chan, scan_done
    );
endinterface

// File: rtl/mux_reg_n.sv
// N-channel multiplexer-register with load, hold, clear and an auto-scan over all channels.
module mux_reg_n #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned NUM_IN = 2,
    parameter int unsigned SEL_W  = 1
) (
    input  logic      clk,
    input  logic      reset,
    mux_reg_n_if.slave bus
);

    localparam int unsigned     NUM_SLOT = 1 << SEL_W;
    localparam logic [SEL_W-1:0] PTR_LAST = SEL_W'(NUM_IN - 1);
    localparam logic [SEL_W:0]   NUM_IN_W = (SEL_W + 1)'(NUM_IN);

    typedef enum logic [1:0] {
        MODE_HOLD  = 2'b00,
        MODE_LOAD  = 2'b01,
        MODE_SCAN  = 2'b10,
        MODE_CLEAR = 2'b11
    } mode_e;

    logic [WIDTH-1:0] slot [NUM_SLOT];

    logic [WIDTH-1:0] q_d,         q_q;
    logic             q_valid_d,   q_valid_q;
    logic [SEL_W-1:0] chan_d,      chan_q;
    logic             scan_done_d, scan_done_q;
    logic [SEL_W-1:0] ptr_d,       ptr_q;

    logic             sel_in_range;

    // Every select code maps to a slot; codes beyond the last channel read as zero.
    for (genvar i = 0; i < int'(NUM_SLOT); i++) begin : g_slot
        if (i < int'(NUM_IN)) begin : g_used
            assign slot[i] = bus.d[i*WIDTH +: WIDTH];
        end else begin : g_unused
            assign slot[i] = '0;
        end
    end

    assign sel_in_range = ({1'b0, bus.sel} < NUM_IN_W);

    // Next-state selection by mode; a disabled block freezes everything but the done pulse.
    always_comb begin
        q_d         = q_q;
        q_valid_d   = q_valid_q;
        chan_d      = chan_q;
        ptr_d       = ptr_q;
        scan_done_d = 1'b0;
        if (!bus.enb_n) begin
            unique case (mode_e'(bus.mode))
                MODE_HOLD: begin
                    ptr_d = '0;
                end
                MODE_LOAD: begin
                    q_d       = sel_in_range ? slot[bus.sel] : '0;
                    q_valid_d = sel_in_range;
                    chan_d    = bus.sel;
                    ptr_d     = '0;
                end
                MODE_SCAN: begin
                    q_d       = slot[ptr_q];
                    q_valid_d = 1'b1;
                    chan_d    = ptr_q;
                    if (ptr_q == PTR_LAST) begin
                        ptr_d       = '0;
                        scan_done_d = 1'b1;
                    end else begin
                        ptr_d = ptr_q + SEL_W'(1);
                    end
                end
                MODE_CLEAR: begin
                    q_d       = '0;
                    q_valid_d = 1'b0;
                    chan_d    = '0;
                    ptr_d     = '0;
                end
                default: begin
                    ptr_d = ptr_q;
                end
            endcase
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_q         <= '0;
            q_valid_q   <= 1'b0;
            chan_q      <= '0;
            scan_done_q <= 1'b0;
            ptr_q       <= '0;
        end else begin
            q_q         <= q_d;
            q_valid_q   <= q_valid_d;
            chan_q      <= chan_d;
            scan_done_q <= scan_done_d;
            ptr_q       <= ptr_d;
        end
    end

    assign bus.q         = q_q;
    assign bus.q_valid   = q_valid_q;
    assign bus.chan      = chan_q;
    assign bus.scan_done = scan_done_q;

endmodule

// File: doc/mux_reg_n.md
# mux_reg_n

Parametrised multiplexer-register: selects one of `NUM_IN` input words of `WIDTH` bits and captures it in an output register. It generalises the 2-input quad mux parts used on the datapath to N channels and arbitrary width. It adds a storage register, an active-low enable and an auto-scan mode that steps through all channels in turn. It sits on the datapath wherever a selected source must be held stable for a following stage, such as the M/A source select or the diagnostic readback scan.

## Interface
- `WIDTH`, default 4: bits per channel; 1..64.
- `NUM_IN`, default 2: number of input channels; 2..16.
- `SEL_W`, default 1: select width; must satisfy `2**SEL_W >= NUM_IN`.
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk`  input  1  clock.
- `reset`  input  1  synchronous, active-high reset.
- `d`  input  `NUM_IN*WIDTH`  flattened channel inputs; channel i is at bits `[i*WIDTH +: WIDTH]`.
- `sel`  input  `SEL_W`  channel select for LOAD mode.
- `mode`  input  2  operating mode: 00 HOLD, 01 LOAD, 10 SCAN, 11 CLEAR.
- `enb_n`  input  1  active-low enable; when high the block holds its complete state.
- `q`  output  `WIDTH`  registered selected word.
- `q_valid`  output  1  asserted when `q` holds a legitimately captured channel.
- `chan`  output  `SEL_W`  index of the channel currently held in `q`.
- `scan_done`  output  1  one-cycle pulse marking the capture of the last channel in a scan pass.

## Operation
- Reset (`reset=1` at a `clk` edge) clears `q`, `q_valid`, `chan`, `scan_done` and the internal scan pointer `ptr` to 0. Reset overrides `enb_n` and `mode`.
- `enb_n=1`: all registers, including `ptr`, hold their values, and `scan_done` is forced to 0.
- The following modes apply only when `enb_n=0`.
- HOLD: `q`, `q_valid` and `chan` hold. `ptr` is set to 0.
- LOAD:
  - If `sel < NUM_IN`: `q <= d[sel]`, `chan <= sel`, `q_valid <= 1`.
  - If `sel >= NUM_IN` (out of range): `q <= 0`, `chan <= sel`, `q_valid <= 0`.
  - `ptr` is set to 0.
- SCAN: `q <= d[ptr]`, `chan <= ptr`, `q_valid <= 1`.
  - If `ptr == NUM_IN-1`: `ptr <= 0` and `scan_done <= 1`.
  - Otherwise: `ptr <= ptr+1`.
  - Scanning continues indefinitely while SCAN mode is held.
- CLEAR: `q <= 0`, `q_valid <= 0`, `chan <= 0`, `ptr <= 0`.
- `scan_done` is 0 in every cycle except the cycle following the capture of channel `NUM_IN-1` in SCAN mode.
- Leaving SCAN mid-pass discards the pass. Re-entering SCAN always starts at channel 0.
  - Exception: a pass paused by `enb_n=1` resumes at the saved `ptr`.
- `ptr` never exceeds `NUM_IN-1`. Wrap-around occurs exactly at `NUM_IN-1`, never at `2**SEL_W-1`.
- The `d` and `sel` inputs are sampled only at the `clk` edge. There is no combinational path from any input to any output.

## Timing
- Every output changes only on the rising edge of `clk`.
- Latency: one cycle from the sampled `d`/`sel`/`mode` to `q`, `q_valid`, `chan` and `scan_done`.
- A full scan pass takes `NUM_IN` enabled cycles.
- Throughput: one new capture per enabled cycle.
- The mode may change on any cycle. The new mode takes effect at the next edge; no idle cycle is required.
- Reset asserted mid-scan: on the next edge all outputs are 0. No `scan_done` is produced for the aborted pass.

## Test plan
- Reset values: apply reset with `mode=10`, `enb_n=0`, then release. Required: `q=0`, `q_valid=0`, `chan=0`, `scan_done=0`. The first SCAN capture after release is channel 0.
- Load (`WIDTH=8`, `NUM_IN=4`, `SEL_W=2`, `d={8'h44,8'h33,8'h22,8'h11}`): apply `mode=01`, `sel=2`. Required one cycle later: `q=8'h33`, `chan=2`, `q_valid=1`. Then apply `mode=00` with `d` changed. Required: `q` stays `8'h33`.
- Full scan (same `d`, `mode=10` for 5 cycles): required `q` sequence `11,22,33,44,11` and `chan` sequence `0,1,2,3,0`. `scan_done` is 1 only in the cycle where `q=44`.
- Enable pause: during a scan, set `enb_n=1` after `q=22` is captured, hold for 3 cycles, then release. Required: `q=22` holds with `scan_done=0` throughout the pause. After release the next capture is `33`.
- Out-of-range select (`NUM_IN=3`, `SEL_W=2`): apply `mode=01`, `sel=3`. Required: `q=0`, `q_valid=0`, `chan=3`. A following CLEAR gives `chan=0`.
- Reset mid-scan: assert reset after `chan=2` is captured. Required next edge: all outputs 0, no `scan_done`. After release, SCAN restarts at `chan=0`.
